// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full_adder shared over WIDTH clocks, LSB first, framed by start/done.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_s;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic             w_accept;
   logic             w_last;
   logic             w_fa_sum;
   logic             w_fa_carry;
   logic [WIDTH-1:0] w_s_next;

   // A new operation may only be taken when no addition is in progress.
   assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last   = (r_cnt == CW'(WIDTH - 1));
   assign w_s_next = {w_fa_sum, r_s[WIDTH-1:1]};

   full_adder u_fa (
      .i_a (r_a[0]),
      .i_b (r_b[0]),
      .i_c (r_carry),
      .o_s (w_fa_sum),
      .o_c (w_fa_carry)
   );

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // NOTE: defaulting w_next first keeps this block purely combinational (no latch).
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_RUN;
         S_RUN:   if (w_last)   w_next = S_DONE;
         S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         S_RUN:   busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_s     <= '0;
         r_carry <= cin;
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_s     <= w_s_next;
         r_carry <= w_fa_carry;
         r_cnt   <= r_cnt + CW'(1);
      end
   end

   // Results move only on the final RUN edge and hold until the next completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum  <= '0;
         cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf  <= 1'b0;
`endif
      end else if ((r_state == S_RUN) && w_last) begin
         sum  <= w_s_next;
         cout <= w_fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
         // On the last edge r_carry is the carry into the MSB.
         ovf  <= r_carry ^ w_fa_carry;
`endif
      end
   end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed bench for serial_adder_seq (WIDTH=8) with a queue scoreboard of expected results.
// Checks ovf only when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder_seq;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf_obs;

   exp_t sb[$];
   exp_t last_exp;
   int   total = 0;
   int   bad   = 0;
   int   pulses;

   always #5 clk = ~clk;

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf;
   assign ovf_obs = ovf;
   serial_adder_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .ovf(ovf), .cout(cout)
   );
`else
   assign ovf_obs = 1'b0;
   serial_adder_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      exp_t       e;
      logic [W:0] t;
      t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      e.s = t[W-1:0];
      e.c = t[W];
      e.v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
      return e;
   endfunction

   // Present an accepted request and record its expected result.
   task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      a     = x;
      b     = y;
      cin   = c;
      start = 1'b1;
      sb.push_back(model(x, y, c));
   endtask

   // 'already' counts edges since (and including) the accepting edge, all spent in RUN.
   task automatic wait_done(input string tag, input int already);
      int   cyc;
      int   busy_n;
      exp_t e;
      cyc    = already;
      busy_n = already;
      while (!done && cyc < 40) begin
         step();
         cyc++;
         if (busy) busy_n++;
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_latency"}, 32'(cyc), 32'(W + 1));
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(W));
      if (sb.size() == 0) begin
         check({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         last_exp = e;
         check({tag, "_sum"}, 32'(sum), 32'(e.s));
         check({tag, "_cout"}, 32'(cout), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
         check({tag, "_ovf"}, 32'(ovf_obs), 32'(e.v));
`endif
      end
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      step();
      step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum",  32'(sum),  32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf",  32'(ovf_obs), 32'd0);
      rst = 1'b0;
      step();

      // 0 + 0
      drive(8'h00, 8'h00, 1'b0);
      step();
      start = 1'b0;
      check("zero_busy_after_e0", 32'(busy), 32'd1);
      wait_done("zero", 1);
      step();
      check("zero_done_one_cycle", 32'(done), 32'd0);
      check("zero_busy_idle", 32'(busy), 32'd0);

      // Unsigned wrap with carry out, no signed overflow
      drive(8'hFF, 8'h01, 1'b0);
      step();
      start = 1'b0;
      wait_done("ff_01", 1);
      step();
      check("ff_01_sum_hold", 32'(sum), 32'(last_exp.s));

      // Signed overflow
      drive(8'h7F, 8'h01, 1'b0);
      step();
      start = 1'b0;
      wait_done("7f_01", 1);
      step();

      // Back-to-back: second start accepted in the DONE cycle
      drive(8'hA5, 8'h5A, 1'b1);
      step();
      start = 1'b0;
      wait_done("a5_5a", 1);
      drive(8'h03, 8'h04, 1'b0);
      step();
      start = 1'b0;
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_sum_hold", 32'(sum), 32'(last_exp.s));
      wait_done("03_04", 1);
      step();

      // start during RUN is ignored
      drive(8'h10, 8'h20, 1'b0);
      step();
      start = 1'b0;
      step();
      a     = 8'h55;
      b     = 8'h66;
      cin   = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done("ign", 3);
      pulses = 0;
      for (int i = 0; i < 2 * W; i++) begin
         step();
         if (done) pulses++;
      end
      check("ign_extra_done", 32'(pulses), 32'd0);
      check("ign_sum_hold", 32'(sum), 32'h30);

      // Reset mid-operation
      drive(8'h11, 8'h22, 1'b0);
      step();
      start = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_sum",  32'(sum),  32'd0);
      check("midrst_cout", 32'(cout), 32'd0);
      pulses = 0;
      for (int i = 0; i < 2 * W; i++) begin
         step();
         if (done || busy) pulses++;
      end
      check("midrst_quiet", 32'(pulses), 32'd0);

      // rst wins over start
      rst = 1'b1;
      start = 1'b1;
      a = 8'h01;
      b = 8'h01;
      step();
      check("rst_start_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      start = 1'b0;
      step();

      // Normal operation after reset
      drive(8'h12, 8'h34, 1'b1);
      step();
      start = 1'b0;
      wait_done("after_rst", 1);
      step();

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
